kv_ledger: RTL and testbench

Account table downstream of the byte-packet assembler. It accepts decoded commands (opcode, 32-bit key, 32-bit value) over a valid/ready handshake and keeps up to DEPTH key/balance entries. It executes create, credit, debit and query operations using a sequential one-entry-per-cycle search, then returns a status and the resulting balance over a second valid/ready handshake.

---
 rtl/kv_ledger.sv | 226 ++++++++++++++++++++++
 tb/tb_kv_ledger.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kv_ledger.sv
// kv_ledger: account table holding up to DEPTH key/balance entries.
// Commands (query/create/credit/debit) arrive over a valid/ready handshake.
// The table is searched one entry per cycle and each command gets exactly
// one status/balance response over a second valid/ready handshake.
// The per-entry compare is registered before the search decision is taken,
// so the search loop runs as a two-stage pipeline (issue, then decide).
module kv_ledger #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          tick_in,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [31:0]   cmd_key,
  input  logic [31:0]   cmd_value,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2:0]    rsp_status,
  output logic [31:0]   rsp_key,
  output logic [31:0]   rsp_balance,
  output logic [CW-1:0] count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] OP_QUERY  = 2'd0;
  localparam logic [1:0] OP_CREATE = 2'd1;
  localparam logic [1:0] OP_CREDIT = 2'd2;
  localparam logic [1:0] OP_DEBIT  = 2'd3;

  localparam logic [2:0] RS_OK           = 3'd0;
  localparam logic [2:0] RS_DUP_KEY      = 3'd1;
  localparam logic [2:0] RS_NOT_FOUND    = 3'd2;
  localparam logic [2:0] RS_FULL         = 3'd3;
  localparam logic [2:0] RS_INSUFFICIENT = 3'd4;
  localparam logic [2:0] RS_OVERFLOW     = 3'd5;

  logic [1:0]    state;

  // Latched command
  logic [1:0]    op_q;
  logic [31:0]   key_q;
  logic [31:0]   value_q;

  // Search pipeline: idx is the entry being issued, chk_* is the registered
  // result of the previous issue that the decision stage looks at.
  logic [CW-1:0] idx;
  logic          chk_valid;
  logic          chk_hit;
  logic          chk_last;
  logic [IW-1:0] chk_idx;
  logic          found_q;
  logic [IW-1:0] hit_idx;

  // Table storage; count alone says which entries hold data.
  logic [31:0]   tbl_key [DEPTH];
  logic [31:0]   tbl_bal [DEPTH];

  logic          issue_hit;
  logic          issue_last;
  logic          search_done;
  logic [31:0]   cur_bal;
  logic [32:0]   sum33;
  logic [2:0]    ex_status;
  logic [31:0]   ex_bal;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_bal;
  logic          cnt_inc;

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Compare stage: never looks at an entry at or beyond count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
    issue_last = 1'b0;
    issue_hit  = 1'b0;
    if (count == '0) begin
      issue_last = 1'b1;
    end else begin
      issue_last = (idx == count - CW'(1));
      issue_hit  = (tbl_key[idx[IW-1:0]] == key_q);
    end
  end

  assign search_done = chk_valid && (chk_hit || chk_last);

  assign cur_bal = tbl_bal[hit_idx];
  assign sum33   = {1'b0, cur_bal} + {1'b0, value_q};

  // Execute stage: status, response balance and the single table write.
  always_comb begin
    ex_status = RS_OK;
    ex_bal    = '0;
    wr_en     = 1'b0;
    wr_idx    = hit_idx;
    wr_bal    = '0;
    cnt_inc   = 1'b0;
    case (op_q)
      OP_CREATE: begin
        if (found_q) begin
          ex_status = RS_DUP_KEY;
          ex_bal    = cur_bal;
        end else if (count == CW'(DEPTH)) begin
          ex_status = RS_FULL;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = count[IW-1:0];
          wr_bal  = value_q;
          cnt_inc = 1'b1;
          ex_bal  = value_q;
        end
      end
      OP_CREDIT: begin
        if (!found_q) begin
          ex_status = RS_NOT_FOUND;
        end else if (sum33[32]) begin
          ex_status = RS_OVERFLOW;
          ex_bal    = cur_bal;
        end else begin
          wr_en  = 1'b1;
          wr_bal = sum33[31:0];
          ex_bal = sum33[31:0];
        end
      end
      OP_DEBIT: begin
        if (!found_q) begin
          ex_status = RS_NOT_FOUND;
        end else if (value_q > cur_bal) begin
          ex_status = RS_INSUFFICIENT;
          ex_bal    = cur_bal;
        end else begin
          wr_en  = 1'b1;
          wr_bal = cur_bal - value_q;
          ex_bal = cur_bal - value_q;
        end
      end
      default: begin // OP_QUERY
        if (found_q) begin
          ex_bal = cur_bal;
        end else begin
          ex_status = RS_NOT_FOUND;
        end
      end
    endcase
  end

  // Control FSM, search pointer, count and response registers.
  always_ff @(posedge tick_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      chk_valid   <= 1'b0;
      count       <= '0;
      rsp_status  <= RS_OK;
      rsp_key     <= '0;
      rsp_balance <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            idx       <= '0;
            chk_valid <= 1'b0;
            state     <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (search_done) begin
            state <= ST_EXEC;
          end else begin
            chk_valid <= 1'b1;
            idx       <= idx + CW'(1);
          end
        end
        ST_EXEC: begin
          rsp_status  <= ex_status;
          rsp_balance <= ex_bal;
          rsp_key     <= key_q;
          if (cnt_inc) count <= count + CW'(1);
          state <= ST_RESP;
        end
        default: begin // ST_RESP
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: command latch and search results, no reset needed.
  always_ff @(posedge tick_in) begin
    if (state == ST_IDLE && cmd_valid) begin
      op_q    <= cmd_op;
      key_q   <= cmd_key;
      value_q <= cmd_value;
    end
    if (state == ST_SEARCH) begin
      if (search_done) begin
        found_q <= chk_hit;
        hit_idx <= chk_idx;
      end else begin
        chk_hit  <= issue_hit;
        chk_last <= issue_last;
        chk_idx  <= idx[IW-1:0];
      end
    end
  end

  // Table write; suppressed when reset lands in the EXEC cycle.
  always_ff @(posedge tick_in) begin
    // NOTE: the table array is deliberately not reset; count marks valid entries, so storage can map to plain RAM.
    if (state == ST_EXEC && wr_en && !rst) begin
      tbl_key[wr_idx] <= key_q;
      tbl_bal[wr_idx] <= wr_bal;
    end
  end

endmodule

// File: tb/tb_kv_ledger.sv
// Testbench for kv_ledger: directed steps plus a random phase, all checked
// against a software ledger (linear search over arrays) kept in the bench.
module tb_kv_ledger;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          tick_in = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [31:0]   cmd_key = '0;
  logic [31:0]   cmd_value = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [2:0]    rsp_status;
  logic [31:0]   rsp_key;
  logic [31:0]   rsp_balance;
  logic [CW-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference ledger
  logic [31:0] m_key [DEPTH];
  logic [31:0] m_bal [DEPTH];
  int          m_cnt = 0;

  kv_ledger #(.DEPTH(DEPTH)) dut (
    .tick_in     (tick_in),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_key     (cmd_key),
    .cmd_value   (cmd_value),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_key     (rsp_key),
    .rsp_balance (rsp_balance),
    .count       (count)
  );

  always #5 tick_in = ~tick_in;

  task automatic step();
    @(posedge tick_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Ledger rules applied directly: returns status, balance and the expected
  // accept-to-rsp_valid latency in cycles.
  task automatic model_exec(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                            output logic [2:0] st, output logic [31:0] bal, output int lat);
    int pos;
    longint unsigned sum;
    pos = -1;
    for (int i = 0; i < m_cnt; i++) if (m_key[i] == key && pos < 0) pos = i;
    lat = (pos >= 0) ? pos + 3 : ((m_cnt == 0) ? 1 : m_cnt) + 2;
    st  = 3'd0;
    bal = 32'd0;
    case (op)
      2'd1: begin
        if (pos >= 0) begin st = 3'd1; bal = m_bal[pos]; end
        else if (m_cnt == DEPTH) st = 3'd3;
        else begin m_key[m_cnt] = key; m_bal[m_cnt] = val; m_cnt++; bal = val; end
      end
      2'd2: begin
        if (pos < 0) st = 3'd2;
        else begin
          sum = longint'(m_bal[pos]) + longint'(val);
          if (sum > 64'hFFFF_FFFF) begin st = 3'd5; bal = m_bal[pos]; end
          else begin m_bal[pos] = 32'(sum); bal = 32'(sum); end
        end
      end
      2'd3: begin
        if (pos < 0) st = 3'd2;
        else if (val > m_bal[pos]) begin st = 3'd4; bal = m_bal[pos]; end
        else begin m_bal[pos] = m_bal[pos] - val; bal = m_bal[pos]; end
      end
      default: begin
        if (pos >= 0) bal = m_bal[pos];
        else st = 3'd2;
      end
    endcase
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_cnt = 0;
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_status", 32'(rsp_status), 32'd0);
    check("reset rsp_key", rsp_key, 32'd0);
    check("reset rsp_balance", rsp_balance, 32'd0);
    check("reset count", 32'(count), 32'd0);
  endtask

  // Issue one command, check latency and the response, hold the response for
  // 'hold' cycles with rsp_ready low, then complete the handshake.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] key,
                        input logic [31:0] val, input int hold);
    logic [2:0]  es;
    logic [31:0] eb;
    int          elat;
    int          cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin step(); cyc++; end
    check({tag, " ready"}, 32'(cmd_ready), 32'd1);
    model_exec(op, key, val, es, eb, elat);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_value = val;
    step();
    cmd_valid = 1'b0;
    cmd_key   = $urandom;
    cmd_value = $urandom;
    check({tag, " busy"}, 32'(cmd_ready), 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin step(); cyc++; end
    check({tag, " latency"}, 32'(cyc), 32'(elat));
    check({tag, " status"}, 32'(rsp_status), 32'(es));
    check({tag, " key"}, rsp_key, key);
    check({tag, " balance"}, rsp_balance, eb);
    check({tag, " count"}, 32'(count), 32'(m_cnt));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold ready"}, 32'(cmd_ready), 32'd0);
      check({tag, " hold status"}, 32'(rsp_status), 32'(es));
      check({tag, " hold key"}, rsp_key, key);
      check({tag, " hold balance"}, rsp_balance, eb);
    end
    rsp_ready = 1'b1;
    step();
    check({tag, " done valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " done ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rv;
    int          sel;

    do_reset();

    // Basic create / query / duplicate / miss
    do_cmd("create5", 2'd1, 32'd5, 32'd100, 0);
    do_cmd("query5", 2'd0, 32'd5, 32'd0, 0);
    do_cmd("dup5", 2'd1, 32'd5, 32'd7, 0);
    do_cmd("query9", 2'd0, 32'd9, 32'd0, 0);

    // Arithmetic edges on key 5 (balance 100)
    do_cmd("debit101", 2'd3, 32'd5, 32'd101, 0);
    do_cmd("debit100", 2'd3, 32'd5, 32'd100, 0);
    do_cmd("creditmax", 2'd2, 32'd5, 32'hFFFF_FFFF, 0);
    do_cmd("credit1", 2'd2, 32'd5, 32'd1, 0);
    do_cmd("creditmiss", 2'd2, 32'd77, 32'd1, 0);
    do_cmd("debitmiss", 2'd3, 32'd77, 32'd1, 0);

    // Backpressure: response held 10 cycles
    do_cmd("backpressure", 2'd0, 32'd5, 32'd0, 10);

    // Fill the table, then overflow it
    do_reset();
    for (int k = 1; k <= DEPTH; k++) do_cmd("fill", 2'd1, 32'(k), 32'(k * 1000), 0);
    do_cmd("full", 2'd1, 32'd99, 32'd1, 0);
    do_cmd("querylast", 2'd0, 32'(DEPTH), 32'd0, 0);
    do_cmd("queryfirst", 2'd0, 32'd1, 32'd0, 0);
    do_cmd("missfull", 2'd0, 32'd99, 32'd0, 0);

    // Reset in the middle of a search drops the command and clears the table
    do_reset();
    do_cmd("pre1", 2'd1, 32'd1, 32'd11, 0);
    do_cmd("pre2", 2'd1, 32'd2, 32'd22, 0);
    do_cmd("pre3", 2'd1, 32'd3, 32'd33, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_key   = 32'd50;
    cmd_value = 32'd500;
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cnt = 0;
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst no rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd("query50", 2'd0, 32'd50, 32'd0, 0);
    do_cmd("query1", 2'd0, 32'd1, 32'd0, 0);

    // Random traffic over a small key space so hits, duplicates and FULL occur
    do_reset();
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       rv = 32'd0;
        1:       rv = 32'hFFFF_FFFF;
        2:       rv = $urandom_range(0, 200);
        default: rv = $urandom;
      endcase
      do_cmd("random", 2'($urandom_range(0, 3)), 32'($urandom_range(0, 20)), rv,
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
